// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one iterative divider between several requesters:
// registers the winner's operands, sequences start/done, routes or discards the result.
module div_share_arbiter #(
    parameter int NUM_REQUESTERS = 2,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_REQUESTERS-1:0]                     req_valid,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]          req_dividend,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]          req_divisor,
    input  logic [NUM_REQUESTERS*$clog2(DATA_WIDTH)-1:0]  req_dividend_CLZ,
    input  logic [NUM_REQUESTERS*$clog2(DATA_WIDTH)-1:0]  req_divisor_CLZ,
    input  logic [NUM_REQUESTERS-1:0]                     req_divisor_is_zero,
    input  logic [NUM_REQUESTERS-1:0]                     req_abort,
    output logic [NUM_REQUESTERS-1:0]                     req_accept,
    output logic [NUM_REQUESTERS-1:0]                     req_done,
    output logic [DATA_WIDTH-1:0]                         req_quotient,
    output logic [DATA_WIDTH-1:0]                         req_remainder,
    output logic                                          busy,
    output logic                                          div_start,
    output logic [DATA_WIDTH-1:0]                         div_dividend,
    output logic [$clog2(DATA_WIDTH)-1:0]                 div_dividend_CLZ,
    output logic [DATA_WIDTH-1:0]                         div_divisor,
    output logic [$clog2(DATA_WIDTH)-1:0]                 div_divisor_CLZ,
    output logic                                          div_divisor_is_zero,
    input  logic                                          div_done,
    input  logic [DATA_WIDTH-1:0]                         div_quotient,
    input  logic [DATA_WIDTH-1:0]                         div_remainder
);

    localparam int CLZW = $clog2(DATA_WIDTH);
    localparam int PTRW = $clog2(NUM_REQUESTERS);
    localparam logic [PTRW-1:0] LAST_IDX = PTRW'(NUM_REQUESTERS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [PTRW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [PTRW-1:0]           owner_q, owner_d;
    logic [DATA_WIDTH-1:0]     dividend_q, dividend_d;
    logic [DATA_WIDTH-1:0]     divisor_q, divisor_d;
    logic [CLZW-1:0]           dividend_clz_q, dividend_clz_d;
    logic [CLZW-1:0]           divisor_clz_q, divisor_clz_d;
    logic                      divisor_zero_q, divisor_zero_d;
    logic [NUM_REQUESTERS-1:0] done_q, done_d;
    logic [DATA_WIDTH-1:0]     quot_q, quot_d;
    logic [DATA_WIDTH-1:0]     rem_q, rem_d;

    logic [NUM_REQUESTERS-1:0] eligible;
    logic                      grant_found;
    logic [PTRW-1:0]           grant_idx;
    logic [PTRW-1:0]           cand_idx;
    logic                      owner_abort;

    assign eligible    = req_valid & ~req_abort;
    assign owner_abort = req_abort[owner_q];

    // First eligible index at or after rr_ptr_q, wrapping modulo NUM_REQUESTERS.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
            cand_idx = PTRW'((32'(rr_ptr_q) + i) % 32'(NUM_REQUESTERS));
            if (!grant_found && eligible[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        dividend_d     = dividend_q;
        divisor_d      = divisor_q;
        dividend_clz_d = dividend_clz_q;
        divisor_clz_d  = divisor_clz_q;
        divisor_zero_d = divisor_zero_q;
        done_d         = '0;
        quot_d         = quot_q;
        rem_d          = rem_q;
        req_accept     = '0;
        div_start      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    req_accept[grant_idx] = 1'b1;
                    dividend_d     = req_dividend[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
                    divisor_d      = req_divisor[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
                    dividend_clz_d = req_dividend_CLZ[32'(grant_idx) * CLZW +: CLZW];
                    divisor_clz_d  = req_divisor_CLZ[32'(grant_idx) * CLZW +: CLZW];
                    divisor_zero_d = req_divisor_is_zero[grant_idx];
                    owner_d        = grant_idx;
                    rr_ptr_d       = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTRW'(1);
                    state_d        = ST_START;
                end
            end
            ST_START: begin
                // Abort before launch: the divider never sees the operation.
                if (owner_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    div_start = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (div_done) begin
                    state_d = ST_IDLE;
                    if (!owner_abort) begin
                        done_d[owner_q] = 1'b1;
                        quot_d          = div_quotient;
                        rem_d           = div_remainder;
                    end
                end else if (owner_abort) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (div_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            dividend_q     <= '0;
            divisor_q      <= '0;
            dividend_clz_q <= '0;
            divisor_clz_q  <= '0;
            divisor_zero_q <= 1'b0;
            done_q         <= '0;
            quot_q         <= '0;
            rem_q          <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            dividend_q     <= dividend_d;
            divisor_q      <= divisor_d;
            dividend_clz_q <= dividend_clz_d;
            divisor_clz_q  <= divisor_clz_d;
            divisor_zero_q <= divisor_zero_d;
            done_q         <= done_d;
            quot_q         <= quot_d;
            rem_q          <= rem_d;
        end
    end

    assign busy                = (state_q != ST_IDLE);
    assign req_done            = done_q;
    assign req_quotient        = quot_q;
    assign req_remainder       = rem_q;
    assign div_dividend        = dividend_q;
    assign div_divisor         = divisor_q;
    assign div_dividend_CLZ    = dividend_clz_q;
    assign div_divisor_CLZ     = divisor_clz_q;
    assign div_divisor_is_zero = divisor_zero_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: transaction-level reference model, divider emulation,
// arbitration vector table, directed corner sequences and randomized traffic.
module tb_div_share_arbiter;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid, req_abort, req_divisor_is_zero;
    logic [N*DW-1:0] req_dividend, req_divisor;
    logic [N*CW-1:0] req_dividend_CLZ, req_divisor_CLZ;
    logic [N-1:0]  req_accept, req_done;
    logic [DW-1:0] req_quotient, req_remainder;
    logic          busy, div_start;
    logic [DW-1:0] div_dividend, div_divisor;
    logic [CW-1:0] div_dividend_CLZ, div_divisor_CLZ;
    logic          div_divisor_is_zero;
    logic          div_done;
    logic [DW-1:0] div_quotient, div_remainder;

    logic [DW-1:0] opa [N];
    logic [DW-1:0] opb [N];
    logic [CW-1:0] ca  [N];
    logic [CW-1:0] cb  [N];
    logic          zf  [N];

    assign req_dividend        = {opa[2], opa[1], opa[0]};
    assign req_divisor         = {opb[2], opb[1], opb[0]};
    assign req_dividend_CLZ    = {ca[2], ca[1], ca[0]};
    assign req_divisor_CLZ     = {cb[2], cb[1], cb[0]};
    assign req_divisor_is_zero = {zf[2], zf[1], zf[0]};

    div_share_arbiter #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
        .req_dividend_CLZ(req_dividend_CLZ), .req_divisor_CLZ(req_divisor_CLZ),
        .req_divisor_is_zero(req_divisor_is_zero), .req_abort(req_abort),
        .req_accept(req_accept), .req_done(req_done),
        .req_quotient(req_quotient), .req_remainder(req_remainder),
        .busy(busy), .div_start(div_start),
        .div_dividend(div_dividend), .div_dividend_CLZ(div_dividend_CLZ),
        .div_divisor(div_divisor), .div_divisor_CLZ(div_divisor_CLZ),
        .div_divisor_is_zero(div_divisor_is_zero),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one outstanding transaction, described by whether it is
    // held, whether it is in its launch cycle, and whether its result is doomed.
    bit            m_op, m_fresh, m_doomed;
    int            m_owner, m_rr;
    logic [DW-1:0] m_a, m_b, m_q, m_r;
    logic [CW-1:0] m_ca, m_cb;
    logic          m_z;
    logic [N-1:0]  m_done;

    // Divider emulation
    int            lat  = 4;
    int            dcnt = 0;
    logic [DW-1:0] dq, dr;

    logic [N-1:0]  last_acc;
    logic          last_start;
    logic [N-1:0]  exp_acc_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: got timeout expected completion at t=%0t", name, $time);
    endtask

    task automatic model_reset();
        m_op = 0; m_fresh = 0; m_doomed = 0; m_owner = 0; m_rr = 0;
        m_a = '0; m_b = '0; m_q = '0; m_r = '0; m_ca = '0; m_cb = '0; m_z = 1'b0;
        m_done = '0;
    endtask

    task automatic step();
        logic [N-1:0] elig, e_acc, n_done;
        int g, n_owner, n_rr, cand;
        bit e_start, oab, n_op, n_fresh, n_doomed;
        logic [DW-1:0] n_a, n_b, n_q, n_r;
        logic [CW-1:0] n_ca, n_cb;
        logic n_z;
        @(negedge clk);
        if (!rst) model_reset();
        elig = req_valid & ~req_abort;
        g = -1;
        if (!m_op)
            for (int k = 0; k < N; k++) begin
                cand = (m_rr + k) % N;
                if (g < 0 && elig[cand]) g = cand;
            end
        e_acc = '0;
        if (g >= 0) e_acc[g] = 1'b1;
        oab = req_abort[m_owner];
        e_start = m_op && m_fresh && !oab;
        chk("req_accept", req_accept, e_acc);
        chk("div_start", div_start, e_start);
        chk("busy", busy, m_op);
        chk("req_done", req_done, m_done);
        chk("req_quotient", req_quotient, m_q);
        chk("req_remainder", req_remainder, m_r);
        chk("div_dividend", div_dividend, m_a);
        chk("div_divisor", div_divisor, m_b);
        chk("div_dividend_CLZ", div_dividend_CLZ, m_ca);
        chk("div_divisor_CLZ", div_divisor_CLZ, m_cb);
        chk("div_divisor_is_zero", div_divisor_is_zero, m_z);
        last_acc = req_accept;
        last_start = div_start;
        exp_acc_last = e_acc;
        if (div_start === 1'b1) begin
            dcnt = lat;
            dq = (div_divisor == 0) ? '1 : div_dividend / div_divisor;
            dr = (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
        end
        n_op = m_op; n_fresh = m_fresh; n_doomed = m_doomed; n_owner = m_owner; n_rr = m_rr;
        n_a = m_a; n_b = m_b; n_ca = m_ca; n_cb = m_cb; n_z = m_z; n_q = m_q; n_r = m_r;
        n_done = '0;
        if (!m_op) begin
            if (g >= 0) begin
                n_op = 1; n_fresh = 1; n_doomed = 0; n_owner = g; n_rr = (g + 1) % N;
                n_a = opa[g]; n_b = opb[g]; n_ca = ca[g]; n_cb = cb[g]; n_z = zf[g];
            end
        end else if (m_fresh) begin
            if (oab) n_op = 0; else n_fresh = 0;
        end else if (m_doomed) begin
            if (div_done) begin n_op = 0; n_doomed = 0; end
        end else if (div_done) begin
            n_op = 0;
            if (!oab) begin
                n_done[m_owner] = 1'b1;
                n_q = (m_b == 0) ? '1 : m_a / m_b;
                n_r = (m_b == 0) ? m_a : m_a % m_b;
            end
        end else if (oab) begin
            n_doomed = 1;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_op = n_op; m_fresh = n_fresh; m_doomed = n_doomed; m_owner = n_owner; m_rr = n_rr;
            m_a = n_a; m_b = n_b; m_ca = n_ca; m_cb = n_cb; m_z = n_z;
            m_q = n_q; m_r = n_r; m_done = n_done;
        end
        div_done = 1'b0;
        if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
                div_done = 1'b1; div_quotient = dq; div_remainder = dr;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || m_op) && n < 100) begin step(); n++; end
        if (n >= 100) fail("wait_idle");
    endtask

    task automatic wait_accept(input int idx);
        int n = 0;
        while (last_acc[idx] !== 1'b1 && n < 100) begin step(); n++; end
        if (n >= 100) fail("wait_accept");
    endtask

    task automatic set_ops(input int i);
        opa[i] = 16'($urandom);
        opb[i] = 16'($urandom_range(1, 65535));
        ca[i]  = 4'($urandom);
        cb[i]  = 4'($urandom);
        zf[i]  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] abort;
        logic [N-1:0] exp_acc;
    } vec_t;

    vec_t tbl [11];
    bit   pend [N];
    int   gq [$];
    int   n, done0;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; req_valid = '0; req_abort = '0;
        div_done = 1'b0; div_quotient = '0; div_remainder = '0;
        for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; ca[i] = '0; cb[i] = '0; zf[i] = 1'b0; end
        model_reset();

        // Round-robin walk from reset (pointer starts at 0)
        tbl[0]  = '{3'b111, 3'b000, 3'b001};
        tbl[1]  = '{3'b111, 3'b000, 3'b010};
        tbl[2]  = '{3'b111, 3'b100, 3'b001};
        tbl[3]  = '{3'b101, 3'b000, 3'b100};
        tbl[4]  = '{3'b010, 3'b000, 3'b010};
        tbl[5]  = '{3'b011, 3'b000, 3'b001};
        tbl[6]  = '{3'b000, 3'b000, 3'b000};
        tbl[7]  = '{3'b110, 3'b010, 3'b100};
        tbl[8]  = '{3'b110, 3'b000, 3'b010};
        tbl[9]  = '{3'b100, 3'b100, 3'b000};
        tbl[10] = '{3'b111, 3'b000, 3'b100};

        do_reset();
        chk("reset_busy", busy, 1'b0);
        chk("reset_req_done", req_done, 3'b000);
        chk("reset_div_dividend", div_dividend, 16'h0000);

        lat = 3;
        for (int i = 0; i < 11; i++) begin
            for (int r = 0; r < N; r++) set_ops(r);
            req_valid = tbl[i].valid;
            req_abort = tbl[i].abort;
            step();
            chk($sformatf("tbl_accept[%0d]", i), last_acc, tbl[i].exp_acc);
            req_valid = '0; req_abort = '0;
            wait_idle();
        end

        // Single request 100/7 with a 10-cycle divider
        lat = 10;
        opa[0] = 16'd100; opb[0] = 16'd7; zf[0] = 1'b0;
        req_valid = 3'b001;
        step();
        chk("single_accept", last_acc, 3'b001);
        req_valid = '0;
        step();
        chk("single_start", last_start, 1'b1);
        n = 0;
        while (div_done !== 1'b1 && n < 40) begin step(); n++; end
        if (n >= 40) fail("single_div_done");
        step();
        chk("single_req_done", req_done, 3'b001);
        chk("single_quotient", req_quotient, 16'd14);
        chk("single_remainder", req_remainder, 16'd2);
        wait_idle();

        // Round-robin fairness with continuous requests from reset
        do_reset();
        lat = 3;
        set_ops(0); set_ops(1);
        req_valid = 3'b011;
        for (int c = 0; c < 40; c++) begin
            step();
            for (int i = 0; i < N; i++) if (last_acc[i]) gq.push_back(i);
        end
        req_valid = '0;
        wait_idle();
        if (gq.size() < 4) fail("rr_grant_count");
        else for (int i = 0; i < 4; i++) chk($sformatf("rr_grant[%0d]", i), gq[i], i % 2);

        // Abort in START
        set_ops(1);
        req_valid = 3'b010;
        step();
        chk("abort_start_accept", last_acc, 3'b010);
        req_valid = '0; req_abort = 3'b010;
        step();
        chk("abort_start_no_start", last_start, 1'b0);
        req_abort = '0;
        step();
        chk("abort_start_idle", busy, 1'b0);
        chk("abort_start_no_done", req_done, 3'b000);

        // Abort in BUSY, with requester 1 waiting
        lat = 8;
        set_ops(0); set_ops(1);
        req_valid = 3'b001;
        step();
        req_valid = 3'b010;
        step(); step(); step(); step();
        req_abort = 3'b001;
        step();
        req_abort = '0;
        done0 = 0;
        n = 0;
        while (last_acc[1] !== 1'b1 && n < 40) begin
            step(); n++;
            if (req_done[0] === 1'b1) done0++;
        end
        if (n >= 40) fail("abort_busy_accept1");
        chk("abort_busy_no_done0", done0, 0);
        req_valid = '0;
        wait_idle();

        // Abort coinciding with div_done
        lat = 5;
        set_ops(2);
        req_valid = 3'b100;
        step();
        req_valid = '0;
        n = 0;
        while (div_done !== 1'b1 && n < 40) begin step(); n++; end
        if (n >= 40) fail("sim_div_done");
        req_abort = 3'b100;
        step();
        req_abort = '0;
        chk("sim_no_done", req_done, 3'b000);
        chk("sim_idle", busy, 1'b0);
        step();

        // Illegal div_done in IDLE and in START
        div_done = 1'b1; div_quotient = 16'hbeef; div_remainder = 16'hbeef;
        step();
        chk("idle_done_ignored", busy, 1'b0);
        set_ops(1);
        lat = 3;
        req_valid = 3'b010;
        step();
        req_valid = '0;
        div_done = 1'b1; div_quotient = 16'hdead; div_remainder = 16'hdead;
        step();
        chk("start_done_ignored", busy, 1'b1);
        wait_idle();

        // Reset mid-BUSY; stale divider completion must be ignored
        lat = 12;
        set_ops(0);
        req_valid = 3'b001;
        step();
        req_valid = '0;
        step(); step(); step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_div_divisor", div_divisor, 16'h0000);
        chk("rst_quotient", req_quotient, 16'h0000);
        n = 0;
        while (dcnt != 0 && n < 40) begin step(); n++; end
        step();
        step();
        chk("rst_stale_done_ignored", req_done, 3'b000);
        for (int r = 0; r < N; r++) set_ops(r);
        lat = 2;
        req_valid = 3'b111;
        step();
        chk("rst_rr_ptr_zero", last_acc, 3'b001);
        req_valid = '0;
        wait_idle();

        // Randomized traffic
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1;
                    set_ops(i);
                    if ($urandom_range(0, 9) == 0) begin opb[i] = '0; zf[i] = 1'b1; end
                end
                req_valid[i] = pend[i];
                req_abort[i] = ($urandom_range(0, 11) == 0);
            end
            lat = $urandom_range(1, 6);
            step();
            for (int i = 0; i < N; i++)
                if (exp_acc_last[i] || (req_abort[i] && pend[i])) pend[i] = 0;
        end
        req_valid = '0; req_abort = '0;
        wait_idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
